task_done_responder: RTL and testbench

//   Responder side of the task launch/complete handshake. Accepts task-start requests (id + duration)
//   and runs up to NUM_SLOTS tasks concurrently, fork/join_none style: acceptance never waits for

---
 rtl/task_resp_pkg.sv | 21 ++
 rtl/task_slot.sv | 55 +++++
 rtl/task_done_responder.sv | 122 ++++++++++++
 tb/tb_task_done_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_resp_pkg.sv
// Shared types for the task completion responder.
// Slot states, default widths and the completion record.
package task_resp_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_RUN  = 2'd1,
        SLOT_PEND = 2'd2
    } slot_state_e;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int ID_W_DEF      = 4;
    localparam int DUR_W_DEF     = 8;
    localparam int TS_W_DEF      = 16;

    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [TS_W_DEF-1:0] ts;
    } done_rec_t;

endpackage

// File: rtl/task_slot.sv
// One task timer: latches id, counts duration down,
// stamps expiry time and waits to be drained.
module task_slot
    import task_resp_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int DUR_W = DUR_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ID_W-1:0]  load_id,
    input  logic [DUR_W-1:0] load_dur,
    input  logic [TS_W-1:0]  cur_ts,
    input  logic             release_slot,
    output slot_state_e      state,
    output logic [ID_W-1:0]  id,
    output logic [TS_W-1:0]  exp_ts
);

    logic [DUR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SLOT_IDLE;
            cnt    <= '0;
            id     <= '0;
            exp_ts <= '0;
        end else begin
            unique case (state)
                SLOT_IDLE: begin
                    if (start) begin
                        state <= SLOT_RUN;
                        cnt   <= load_dur;
                        id    <= load_id;
                    end
                end
                SLOT_RUN: begin
                    if (cnt == '0) begin
                        state  <= SLOT_PEND;
                        exp_ts <= cur_ts;
                    end else begin
                        cnt <= cnt - DUR_W'(1);
                    end
                end
                SLOT_PEND: begin
                    if (release_slot) state <= SLOT_IDLE;
                end
                default: state <= SLOT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/task_done_responder.sv
// Runs up to NUM_SLOTS task timers concurrently and
// streams completions (id, expiry timestamp) in finish order.
module task_done_responder
    import task_resp_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int DUR_W     = DUR_W_DEF,
    parameter int TS_W      = TS_W_DEF,
    localparam int CNT_W    = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    input  logic [DUR_W-1:0] req_dur,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [ID_W-1:0]  done_id,
    output logic [TS_W-1:0]  done_ts,
    output logic [CNT_W-1:0] in_flight
);

    logic [TS_W-1:0]      ts;
    logic                 ready_en;
    slot_state_e          st  [NUM_SLOTS];
    logic [ID_W-1:0]      sid [NUM_SLOTS];
    logic [TS_W-1:0]      sts [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] start_vec;
    logic [NUM_SLOTS-1:0] rel_vec;
    logic                 free_found;
    logic                 pend_found;
    logic                 accept;
    logic                 load;
    logic [ID_W-1:0]      nxt_id;
    logic [TS_W-1:0]      nxt_ts;

    // Lowest-index IDLE slot takes a start; lowest-index PEND slot drains.
    always_comb begin
        free_found = 1'b0;
        pend_found = 1'b0;
        start_vec  = '0;
        rel_vec    = '0;
        nxt_id     = '0;
        nxt_ts     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && st[i] == SLOT_IDLE) begin
                start_vec[i] = 1'b1;
                free_found   = 1'b1;
            end
            if (!pend_found && st[i] == SLOT_PEND) begin
                rel_vec[i] = 1'b1;
                pend_found = 1'b1;
                nxt_id     = sid[i];
                nxt_ts     = sts[i];
            end
        end
        req_ready = ready_en && free_found;
        accept    = req_valid && req_ready;
        load      = (!done_valid || done_ready) && pend_found;
        start_vec = start_vec & {NUM_SLOTS{accept}};
        rel_vec   = rel_vec & {NUM_SLOTS{load}};
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        task_slot #(
            .ID_W  (ID_W),
            .DUR_W (DUR_W),
            .TS_W  (TS_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .start        (start_vec[g]),
            .load_id      (req_id),
            .load_dur     (req_dur),
            .cur_ts       (ts),
            .release_slot (rel_vec[g]),
            .state        (st[g]),
            .id           (sid[g]),
            .exp_ts       (sts[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            ready_en <= 1'b0;
        end else begin
            ts       <= ts + TS_W'(1);
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_valid <= 1'b0;
            done_id    <= '0;
            done_ts    <= '0;
        end else if (load) begin
            done_valid <= 1'b1;
            done_id    <= nxt_id;
            done_ts    <= nxt_ts;
        end else if (done_ready) begin
            done_valid <= 1'b0;
        end
    end

    // Only IDLE->RUN and PEND->IDLE change the busy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            unique case ({accept, load})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_task_done_responder.sv
// Bench for task_done_responder with a 4-bit timestamp
// so wrap-around is reached quickly.
module tb_task_done_responder;

    localparam int NS = 4;
    localparam int IW = 4;
    localparam int DW = 8;
    localparam int TW = 4;
    localparam int CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_id = '0;
    logic [DW-1:0] req_dur = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [IW-1:0] done_id;
    logic [TW-1:0] done_ts;
    logic [CW-1:0] in_flight;

    int            n_vec = 0;
    int            n_err = 0;
    logic [TW-1:0] tb_ts = '0;

    typedef struct {
        logic [IW-1:0] id;
        logic [TW-1:0] ts;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] dur;
        int            lat;
    } vec_t;
    vec_t vecs[6];

    task_done_responder #(
        .NUM_SLOTS (NS),
        .ID_W      (IW),
        .DUR_W     (DW),
        .TS_W      (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_id     (req_id),
        .req_dur    (req_dur),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_id    (done_id),
        .done_ts    (done_ts),
        .in_flight  (in_flight)
    );

    always #5 clk = ~clk;

    // Reference time base: value sampled by the DUT at the next edge.
    always @(posedge clk) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + TW'(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done_valid === 1'b1 && done_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got id %0h ts %0h, none expected",
                         done_id, done_ts);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_id", 32'(done_id), 32'(e.id));
                chk("done_ts", 32'(done_ts), 32'(e.ts));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] id, input logic [TW-1:0] ts);
        exp_t e;
        e.id = id;
        e.ts = ts;
        q.push_back(e);
    endtask

    task automatic issue(input logic [IW-1:0] id, input logic [DW-1:0] dur,
                         output logic [TW-1:0] ta);
        int n = 0;
        while (1) begin
            tick();
            req_valid = 1'b1;
            req_id    = id;
            req_dur   = dur;
            if (req_ready) break;
            n++;
            if (n > 100) begin
                chk("issue_timeout", 32'(n), 32'd0);
                break;
            end
        end
        ta = tb_ts;
    endtask

    task automatic wait_drain();
        int n = 0;
        tick();
        req_valid = 1'b0;
        while (n < 300 && !(q.size() == 0 && in_flight == '0 && !done_valid)) begin
            tick();
            n++;
        end
        chk("drain", 32'(n < 300), 32'd1);
    endtask

    initial begin
        logic [TW-1:0] ta, tb, tc, t5;
        int k;

        vecs[0] = '{id: 4'h3, dur: 8'd0, lat: 3};
        vecs[1] = '{id: 4'h5, dur: 8'd1, lat: 4};
        vecs[2] = '{id: 4'h7, dur: 8'd2, lat: 5};
        vecs[3] = '{id: 4'hF, dur: 8'd7, lat: 10};
        vecs[4] = '{id: 4'h1, dur: 8'd3, lat: 6};
        vecs[5] = '{id: 4'hA, dur: 8'd0, lat: 3};

        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_done_ts", 32'(done_ts), 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        rst = 1'b0;
        chk("ready_at_release", 32'(req_ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(req_ready), 32'd1);
        done_ready = 1'b1;

        // Single tasks: latency from accept to done_valid, and record contents.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].id, vecs[i].dur, ta);
            push(vecs[i].id, TW'(ta + vecs[i].dur + 1));
            k = 0;
            do begin
                tick();
                req_valid = 1'b0;
                k++;
            end while (!done_valid && k < 40);
            chk("latency", 32'(k), 32'(vecs[i].lat));
            wait_drain();
        end

        // Completion order follows expiry, not start order.
        issue(4'h2, 8'd10, ta);
        issue(4'h1, 8'd20, tb);
        issue(4'h3, 8'd0, tc);
        push(4'h3, TW'(tc + 1));
        push(4'h2, TW'(ta + 11));
        push(4'h1, TW'(tb + 21));
        wait_drain();

        // Full: fifth start stalls until the first slot drains.
        issue(4'h8, 8'd5, ta);
        issue(4'h9, 8'd5, tb);
        issue(4'hB, 8'd5, tc);
        push(4'h8, TW'(ta + 6));
        push(4'h9, TW'(tb + 6));
        push(4'hB, TW'(tc + 6));
        issue(4'hC, 8'd5, tc);
        push(4'hC, TW'(tc + 6));
        tick();
        req_valid = 1'b0;
        chk("full_in_flight", 32'(in_flight), 32'd4);
        chk("full_req_ready", 32'(req_ready), 32'd0);
        issue(4'hD, 8'd5, t5);
        push(4'hD, TW'(t5 + 6));
        chk("full_accept_ts", 32'(t5), 32'(TW'(ta + 8)));
        wait_drain();

        // Simultaneous expiry under backpressure.
        done_ready = 1'b0;
        issue(4'h4, 8'd3, ta);
        issue(4'h6, 8'd2, tb);
        push(4'h4, TW'(ta + 4));
        push(4'h6, TW'(ta + 4));
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!done_valid && k < 20) begin
            tick();
            k++;
        end
        chk("bp_in_flight", 32'(in_flight), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(done_valid), 32'd1);
            chk("bp_id", 32'(done_id), 32'h4);
            chk("bp_ts", 32'(done_ts), 32'(TW'(ta + 4)));
            tick();
        end
        done_ready = 1'b1;
        tick();
        chk("b2b_valid", 32'(done_valid), 32'd1);
        chk("b2b_id", 32'(done_id), 32'h6);
        wait_drain();

        // Reset mid-operation drops everything.
        done_ready = 1'b0;
        issue(4'h1, 8'd0, ta);
        issue(4'h2, 8'd30, ta);
        issue(4'h3, 8'd30, ta);
        issue(4'h5, 8'd30, ta);
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!done_valid && k < 20) begin
            tick();
            k++;
        end
        chk("pre_rst_valid", 32'(done_valid), 32'd1);
        chk("pre_rst_in_flight", 32'(in_flight), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(done_valid), 32'd0);
        chk("mid_rst_id", 32'(done_id), 32'd0);
        chk("mid_rst_ts", 32'(done_ts), 32'd0);
        chk("mid_rst_in_flight", 32'(in_flight), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        done_ready = 1'b1;
        repeat (40) tick();
        chk("post_rst_in_flight", 32'(in_flight), 32'd0);
        chk("post_rst_valid", 32'(done_valid), 32'd0);

        // Timestamp wrap: expiries at 15 then 0.
        k = 0;
        while (tb_ts != TW'(7) && k < 20) begin
            tick();
            k++;
        end
        issue(4'hE, 8'd6, ta);
        issue(4'hD, 8'd6, tb);
        push(4'hE, 4'd15);
        push(4'hD, 4'd0);
        chk("wrap_accept_ts", 32'(ta), 32'd8);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
